// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types for the rx frame release controller
package rx_pkg;

    localparam int LEN_W_DEF = 11;

    // Descriptor word layout is {ok, len[LEN_W-1:0]}; ok sits in the MSB.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_TAIL
    } rd_state_t;

endpackage

// File: rtl/rx_frame_desc_fifo.sv
// rtl/rx_frame_desc_fifo.sv - small synchronous descriptor FIFO (push/pop/full/empty)
module rx_frame_desc_fifo #(
    parameter int W  = 12,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // Full is judged on the pre-pop count, so a push into a full queue is lost
    // even when a pop happens in the same cycle.
    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rx_frame_release_ctrl.sv
// rtl/rx_frame_release_ctrl.sv - releases verdicted rx frames from the data/control FIFOs to the client
// Optional: RX_DROP_BAD_EN masks client byte valids of bad frames.
module rx_frame_release_ctrl
    import rx_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int STAT_AW = 2
) (
    input  logic       rxclk,
    input  logic       reset_n,
    input  logic       wr_word,
    input  logic       wr_frame_end,
    input  logic       crc_done,
    input  logic       crc_ok,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rxc,
    output logic       fifo_rd_en,
    output logic [7:0] rx_data_valid,
    output logic       rx_good_frame,
    output logic       rx_bad_frame,
    output logic       stat_overflow
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    rd_state_t        state, state_nxt;
    logic [LEN_W-1:0] wr_len;
    logic [LEN_W-1:0] pend_len;
    logic [LEN_W-1:0] frame_len;
    logic [LEN_W-1:0] push_len;
    logic [LEN_W-1:0] rd_cnt;
    logic             frame_end;
    logic             desc_push;
    logic [LEN_W:0]   q_dout;
    logic             q_full;
    logic             q_empty;
    logic             rd;
    logic             rd_v;
    logic             last_v;
    logic             bad;

    assign frame_end = wr_word & wr_frame_end;
    assign frame_len = (wr_len == LEN_MAX) ? LEN_MAX : wr_len + LEN_ONE;
    // A verdict arriving with the last word takes the live count; pend_len is not yet loaded.
    assign push_len  = frame_end ? frame_len : pend_len;
    assign desc_push = crc_done & (push_len != '0);

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            wr_len        <= '0;
            pend_len      <= '0;
            stat_overflow <= 1'b0;
        end else begin
            if (frame_end)
                wr_len <= '0;
            else if (wr_word && wr_len != LEN_MAX)
                wr_len <= wr_len + LEN_ONE;

            if (crc_done)
                pend_len <= '0;
            else if (frame_end)
                pend_len <= frame_len;

            if (desc_push && q_full)
                stat_overflow <= 1'b1;
        end
    end

    rx_frame_desc_fifo #(
        .W  (LEN_W + 1),
        .AW (STAT_AW)
    ) u_desc_fifo (
        .clk   (rxclk),
        .rst_n (reset_n),
        .push  (desc_push),
        .din   ({crc_ok, push_len}),
        .pop   (state == ST_LOAD),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        case (state)
            ST_IDLE:  if (!q_empty) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                rd = (rd_cnt != '0) & ~fifo_empty;
                if (rd && rd_cnt == LEN_ONE) state_nxt = ST_TAIL;
            end
            ST_TAIL:  state_nxt = q_empty ? ST_IDLE : ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
            bad    <= 1'b0;
            rd_v   <= 1'b0;
            last_v <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_LOAD) begin
                rd_cnt <= q_dout[LEN_W-1:0];
                bad    <= ~q_dout[LEN_W];
            end else if (rd) begin
                rd_cnt <= rd_cnt - LEN_ONE;
            end
            rd_v   <= rd;
            last_v <= rd & (rd_cnt == LEN_ONE);
        end
    end

    assign fifo_rd_en    = rd;
    assign rx_good_frame = last_v & ~bad;
    assign rx_bad_frame  = last_v & bad;

    // bad holds from LOAD through TAIL, covering the final word's valid cycle.
`ifdef RX_DROP_BAD_EN
    assign rx_data_valid = (rd_v & ~bad) ? fifo_rxc : 8'h00;
`else
    assign rx_data_valid = rd_v ? fifo_rxc : 8'h00;
`endif

endmodule

// File: tb/tb_rx_frame_release_ctrl.sv
// tb/tb_rx_frame_release_ctrl.sv - randomized self-checking bench with a frame-level scoreboard
module tb_rx_frame_release_ctrl;

`ifdef RX_DROP_BAD_EN
    localparam bit DROP_BAD = 1'b1;
`else
    localparam bit DROP_BAD = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         bad;
    } exp_t;

    logic       rxclk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_word = 1'b0;
    logic       wr_frame_end = 1'b0;
    logic       crc_done = 1'b0;
    logic       crc_ok = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rxc = 8'h00;
    logic       fifo_rd_en;
    logic [7:0] rx_data_valid;
    logic       rx_good_frame;
    logic       rx_bad_frame;
    logic       stat_overflow;

    logic [7:0] w_data = 8'h00;
    logic [7:0] data_q[$];
    exp_t       exp_q[$];
    int         rd_cyc[$];
    bit         force_empty = 1'b0;
    bit         rand_empty = 1'b0;
    int         n_chk = 0, n_fail = 0;
    int         cyc = 0, rd_count = 0, good_count = 0, bad_count = 0;
    int         done_frames = 0, verdicts = 0;

    rx_frame_release_ctrl dut (
        .rxclk         (rxclk),
        .reset_n       (reset_n),
        .wr_word       (wr_word),
        .wr_frame_end  (wr_frame_end),
        .crc_done      (crc_done),
        .crc_ok        (crc_ok),
        .fifo_empty    (fifo_empty),
        .fifo_rxc      (fifo_rxc),
        .fifo_rd_en    (fifo_rd_en),
        .rx_data_valid (rx_data_valid),
        .rx_good_frame (rx_good_frame),
        .rx_bad_frame  (rx_bad_frame),
        .stat_overflow (stat_overflow)
    );

    always #5 rxclk = ~rxclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: observe at the falling edge, then act as the data/control FIFO pair.
    task automatic tick();
        bit rd_s, wr_s;
        exp_t e;
        @(negedge rxclk);
        if (rx_data_valid != 8'h00 || rx_good_frame || rx_bad_frame) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {21'd0, rx_good_frame, rx_bad_frame, rx_data_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("word_data", rx_data_valid, e.data);
                chk("good_flag", rx_good_frame, e.last & ~e.bad);
                chk("bad_flag", rx_bad_frame, e.last & e.bad);
            end
        end
        if (rx_good_frame) good_count++;
        if (rx_bad_frame)  bad_count++;
        if (rx_good_frame || rx_bad_frame) done_frames++;
        rd_s = fifo_rd_en;
        wr_s = wr_word;
        if (rd_s) begin
            chk("rd_when_empty", fifo_empty, 1'b0);
            rd_count++;
            rd_cyc.push_back(cyc);
        end
        @(posedge rxclk);
        #1;
        cyc++;
        if (rd_s) begin
            if (data_q.size() == 0) chk("rd_underrun", 1, 0);
            else fifo_rxc = data_q.pop_front();
        end
        if (wr_s) data_q.push_back(w_data);
        if (rand_empty) force_empty = ($urandom_range(0, 3) == 0);
        fifo_empty   = force_empty || (data_q.size() == 0);
        wr_word      = 1'b0;
        wr_frame_end = 1'b0;
        crc_done     = 1'b0;
    endtask

    // Frame-level expectation: a released frame shows its words in write order,
    // the last one carrying the verdict; dropped-bad frames show only the end marker.
    task automatic model_verdict(input logic [7:0] words[$], input bit ok, input bit lost);
        exp_t e;
        if (lost) return;
        verdicts++;
        if (!ok && DROP_BAD) begin
            e.data = 8'h00; e.last = 1'b1; e.bad = 1'b1;
            exp_q.push_back(e);
        end else begin
            foreach (words[i]) begin
                e.data = words[i];
                e.last = (i == words.size() - 1);
                e.bad  = !ok;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_frame(input int len, input int dly, input bit ok, input bit gaps, input bit lost);
        logic [7:0] words[$];
        for (int i = 0; i < len; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) tick();
            wr_word      = 1'b1;
            w_data       = 8'($urandom_range(1, 255));
            words.push_back(w_data);
            wr_frame_end = (i == len - 1);
            if (i == len - 1 && dly == 0) begin
                crc_done = 1'b1;
                crc_ok   = ok;
            end
            tick();
        end
        if (dly > 0) begin
            repeat (dly - 1) tick();
            crc_done = 1'b1;
            crc_ok   = ok;
            tick();
        end
        model_verdict(words, ok, lost);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, exp_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic wait_reads(input int target, input int budget);
        int k = 0;
        while (rd_count < target && k < budget) begin
            tick();
            k++;
        end
        chk("reads_reached", rd_count >= target, 1);
    endtask

    int base_rd, base_good, base_bad, held, k;

    initial begin
        repeat (3) tick();
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", rx_data_valid, 0);
        chk("rst_good", rx_good_frame, 0);
        chk("rst_bad", rx_bad_frame, 0);
        chk("rst_ovf", stat_overflow, 0);
        reset_n = 1'b1;
        tick();

        // 3-word good frame, verdict two cycles after the end
        base_rd = rd_count; base_good = good_count;
        send_frame(3, 2, 1'b1, 1'b0, 1'b0);
        wait_drain("t1_drain", 50);
        chk("t1_reads", rd_count - base_rd, 3);
        chk("t1_good", good_count - base_good, 1);

        // 2-word bad frame
        base_rd = rd_count; base_bad = bad_count; base_good = good_count;
        send_frame(2, 1, 1'b0, 1'b0, 1'b0);
        wait_drain("t2_drain", 50);
        chk("t2_reads", rd_count - base_rd, 2);
        chk("t2_bad", bad_count - base_bad, 1);
        chk("t2_no_good", good_count - base_good, 0);

        // back-to-back 4 + 1: reads of a frame are contiguous, TAIL and LOAD separate frames
        rd_cyc.delete();
        base_good = good_count;
        send_frame(4, 0, 1'b1, 1'b0, 1'b0);
        send_frame(1, 0, 1'b1, 1'b0, 1'b0);
        wait_drain("t3_drain", 60);
        chk("t3_reads", rd_cyc.size(), 5);
        if (rd_cyc.size() == 5) begin
            chk("t3_contig", rd_cyc[3] - rd_cyc[0], 3);
            chk("t3_gap", rd_cyc[4] - rd_cyc[3], 3);
        end
        chk("t3_good", good_count - base_good, 2);

        // fifo_empty pulsed mid-drain of a 6-word frame
        base_rd = rd_count; base_good = good_count;
        send_frame(6, 1, 1'b1, 1'b0, 1'b0);
        wait_reads(base_rd + 2, 50);
        force_empty = 1'b1;
        fifo_empty  = 1'b1;
        held = rd_count;
        repeat (3) tick();
        chk("t5_stall", rd_count - held, 0);
        force_empty = 1'b0;
        fifo_empty  = (data_q.size() == 0);
        wait_drain("t5_drain", 50);
        chk("t5_reads", rd_count - base_rd, 6);
        chk("t5_good", good_count - base_good, 1);

        // verdict with no pending frame pushes nothing
        base_rd = rd_count;
        crc_done = 1'b1;
        crc_ok   = 1'b1;
        tick();
        repeat (10) tick();
        chk("zero_len_reads", rd_count - base_rd, 0);

        // randomized traffic, at most 3 frames in flight so the queue never overflows
        rand_empty = 1'b1;
        for (int f = 0; f < 40; f++) begin
            k = 0;
            while (verdicts - done_frames >= 3 && k < 300) begin
                tick();
                k++;
            end
            send_frame($urandom_range(1, 10), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        rand_empty = 1'b0;
        wait_drain("rand_drain", 2000);
        chk("rand_frames", done_frames, verdicts);
        chk("rand_no_ovf", stat_overflow, 0);

        // overflow: reads blocked; frame 1 is already taken into the drain counter,
        // frames 2-5 fill the 4-entry queue, frame 6 is discarded
        force_empty = 1'b1;
        fifo_empty  = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            send_frame(2, 1, 1'b1, 1'b0, f == 6);
            if (f == 5) chk("t4_ovf_after5", stat_overflow, 0);
        end
        chk("t4_ovf_after6", stat_overflow, 1);
        base_good = good_count;
        force_empty = 1'b0;
        fifo_empty  = (data_q.size() == 0);
        wait_drain("t4_drain", 200);
        chk("t4_released", good_count - base_good, 5);
        chk("t4_orphan_words", data_q.size(), 2);
        chk("t4_ovf_sticky", stat_overflow, 1);
        data_q.delete();
        fifo_empty = 1'b1;

        // reset during drain
        base_rd = rd_count;
        send_frame(8, 1, 1'b1, 1'b0, 1'b0);
        wait_reads(base_rd + 3, 50);
        reset_n = 1'b0;
        #1;
        chk("t6_rd_en", fifo_rd_en, 0);
        chk("t6_valid", rx_data_valid, 0);
        chk("t6_good", rx_good_frame, 0);
        chk("t6_bad", rx_bad_frame, 0);
        chk("t6_ovf", stat_overflow, 0);
        exp_q.delete();
        data_q.delete();
        tick();
        chk("t6_valid_held", rx_data_valid, 0);
        reset_n = 1'b1;
        verdicts = done_frames;
        tick();
        base_rd = rd_count; base_good = good_count;
        send_frame(3, 2, 1'b1, 1'b0, 1'b0);
        wait_drain("t6_drain", 50);
        chk("t6_reads", rd_count - base_rd, 3);
        chk("t6_good_after", good_count - base_good, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
